univ_shift_reg: RTL and testbench

- Parametrised WIDTH-bit universal register built as the successor to the single-bit D flip-flop with reset/preset.
- Per-cycle modes: hold, parallel load, shift left/right, rotate left/right, set-all (preset) and clear.
- A saturating shift counter with a full flag supports serializer and deserializer use.
- Sits in lab datapaths as a general storage, shift or serial-conversion element.

---
 rtl/usr_pkg.sv | 19 +
 rtl/usr_cell.sv | 41 ++++
 rtl/univ_shift_reg.sv | 96 +++++++++
 tb/tb_univ_shift_reg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_SET  = 3'b110,
    MODE_CLR  = 3'b111
  } usr_mode_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal register: mode mux plus a flop with sync reset.
// o_nxt is the non-reset next value, exposed so the top can precompute parity.
module usr_cell
  import usr_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      rst_val,
  input  logic      en,
  input  usr_mode_e mode,
  input  logic      d,
  input  logic      left_nbr,
  input  logic      right_nbr,
  output logic      o_q,
  output logic      o_nxt
);

  logic r_q;

  always_comb begin
    o_nxt = r_q;
    if (en) begin
      case (mode)
        MODE_LOAD:          o_nxt = d;
        MODE_SHL, MODE_ROL: o_nxt = right_nbr;
        MODE_SHR, MODE_ROR: o_nxt = left_nbr;
        MODE_SET:           o_nxt = 1'b1;
        MODE_CLR:           o_nxt = 1'b0;
        default:            o_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_q <= rst_val;
    else       r_q <= o_nxt;
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register with saturating shift counter.
// Define USR_PARITY_EN to build the registered parity output.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [2:0]                    mode,
  input  logic [WIDTH-1:0]              d,
  input  logic                          sl_in,
  input  logic                          sr_in,
  output logic [WIDTH-1:0]              q,
  output logic                          so_left,
  output logic                          so_right,
  output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
  output logic                          full,
  output logic                          par
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  usr_mode_e        w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic             w_lsb_in;
  logic             w_msb_in;
  logic [CW-1:0]    r_cnt;

  assign w_mode   = usr_mode_e'(mode);
  // End bits take either the serial input or the wrapped bit depending on mode.
  assign w_lsb_in = (w_mode == MODE_ROL) ? w_q[WIDTH-1] : sl_in;
  assign w_msb_in = (w_mode == MODE_ROR) ? w_q[0]       : sr_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_left;
    logic w_right;
    if (i == WIDTH-1) begin : g_msb
      assign w_left = w_msb_in;
    end else begin : g_mid_l
      assign w_left = w_q[i+1];
    end
    if (i == 0) begin : g_lsb
      assign w_right = w_lsb_in;
    end else begin : g_mid_r
      assign w_right = w_q[i-1];
    end
    usr_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .rst_val  (RESET_VAL[i]),
      .en       (en),
      .mode     (w_mode),
      .d        (d[i]),
      .left_nbr (w_left),
      .right_nbr(w_right),
      .o_q      (w_q[i]),
      .o_nxt    (w_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      case (w_mode)
        MODE_LOAD, MODE_SET, MODE_CLR: r_cnt <= '0;
        MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR:
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef USR_PARITY_EN
  logic r_par;
  always_ff @(posedge clk) begin
    if (reset) r_par <= ^RESET_VAL;
    else       r_par <= ^w_nxt;
  end
  assign par = r_par;
`else
  assign par = 1'b0;
`endif

  assign q         = w_q;
  assign so_left   = w_q[WIDTH-1];
  assign so_right  = w_q[0];
  assign shift_cnt = r_cnt;
  assign full      = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Table-driven plus randomized scoreboard bench for univ_shift_reg.
module tb_univ_shift_reg;

  localparam int         W  = 8;
  localparam int         CW = $clog2(W + 1);
  localparam logic [7:0] RV = 8'hA5;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         ROL  = 3'b100, ROR  = 3'b101, SET = 3'b110, CLR = 3'b111;

  logic          clk = 1'b0;
  logic          reset, en, sl_in, sr_in;
  logic [2:0]    mode;
  logic [W-1:0]  d, q;
  logic          so_left, so_right, full, par;
  logic [CW-1:0] shift_cnt;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sl_in(sl_in), .sr_in(sr_in), .q(q), .so_left(so_left),
    .so_right(so_right), .shift_cnt(shift_cnt), .full(full), .par(par)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl, sr;
    logic [7:0] eq;
    int         ec;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    int         cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  logic [7:0] m_q;
  int         m_cnt;

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [7:0] dd,
                              logic sl, logic sr, logic [7:0] eq, int ec);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sl = sl; v.sr = sr;
    v.eq = eq; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Drive at negedge, push expectation, compare after the rising edge.
  task automatic apply(int step, logic r, logic e, logic [2:0] m, logic [7:0] dd,
                       logic sl, logic sr, logic [7:0] eq, int ec);
    exp_t x;
    logic exp_par;
    @(negedge clk);
    reset = r; en = e; mode = m; d = dd; sl_in = sl; sr_in = sr;
    x.q = eq; x.cnt = ec;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", step, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
`ifdef USR_PARITY_EN
      exp_par = ^x.q;
`else
      exp_par = 1'b0;
`endif
      chk("q",        step, 32'(q),         32'(x.q));
      chk("shift_cnt",step, 32'(shift_cnt), 32'(x.cnt));
      chk("full",     step, 32'(full),      32'(x.cnt == W));
      chk("par",      step, 32'(par),       32'(exp_par));
      chk("so_left",  step, 32'(so_left),   32'(x.q[7]));
      chk("so_right", step, 32'(so_right),  32'(x.q[0]));
    end
    m_q = eq; m_cnt = ec;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = HOLD; d = '0; sl_in = 1'b0; sr_in = 1'b0;

    // Reset beats en/mode
    vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0));
    // Load then shift left with serial input
    vecs.push_back(mk(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 1, 0, 8'h79, 1));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'hF2, 2));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 1, 0, 8'hE5, 3));
    // Full rotation and saturation
    vecs.push_back(mk(0, 1, LOAD, 8'h81, 0, 0, 8'h81, 0));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'hC0, 1));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h60, 2));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h30, 3));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h18, 4));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h0C, 5));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h06, 6));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h03, 7));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h81, 8));
    vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'hC0, 8));
    // Enable gating
    vecs.push_back(mk(0, 1, SET,  8'h00, 0, 0, 8'hFF, 0));
    vecs.push_back(mk(0, 0, CLR,  8'h00, 0, 0, 8'hFF, 0));
    vecs.push_back(mk(0, 0, CLR,  8'h00, 0, 0, 8'hFF, 0));
    vecs.push_back(mk(0, 0, CLR,  8'h00, 0, 0, 8'hFF, 0));
    vecs.push_back(mk(0, 1, CLR,  8'h00, 0, 0, 8'h00, 0));
    // Deserialize via shift right
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'h80, 1));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 0, 8'h40, 2));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'hA0, 3));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'hD0, 4));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 0, 8'h68, 5));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 0, 8'h34, 6));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'h9A, 7));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 0, 8'h4D, 8));
    // Reset mid-sequence
    vecs.push_back(mk(0, 1, CLR,  8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'h80, 1));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'hC0, 2));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'hE0, 3));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 1, 8'hF0, 4));
    vecs.push_back(mk(1, 1, SHR,  8'h00, 0, 1, 8'hA5, 0));
    // Reset with en low, then rotate left and hold
    vecs.push_back(mk(0, 1, LOAD, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, SHL,  8'h00, 1, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 1, LOAD, 8'h80, 0, 0, 8'h80, 0));
    vecs.push_back(mk(0, 1, ROL,  8'h00, 0, 0, 8'h01, 1));
    vecs.push_back(mk(0, 1, SHL,  8'h00, 0, 0, 8'h02, 2));
    vecs.push_back(mk(0, 1, SHR,  8'h00, 0, 0, 8'h01, 3));
    vecs.push_back(mk(0, 1, HOLD, 8'h00, 0, 0, 8'h01, 3));

    foreach (vecs[i])
      apply(i, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d,
            vecs[i].sl, vecs[i].sr, vecs[i].eq, vecs[i].ec);

    // Randomized traffic against a behavioural model
    for (int k = 0; k < 300; k++) begin
      logic       r, e, sl, sr;
      logic [2:0] m;
      logic [7:0] dd, nq;
      int         nc;
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      sl = 1'($urandom);
      sr = 1'($urandom);
      nq = m_q; nc = m_cnt;
      if (r) begin
        nq = RV; nc = 0;
      end else if (e) begin
        case (m)
          LOAD: begin nq = dd;                       nc = 0; end
          SHL:  begin nq = {m_q[6:0], sl};           nc = (m_cnt < W) ? m_cnt + 1 : W; end
          SHR:  begin nq = {sr, m_q[7:1]};           nc = (m_cnt < W) ? m_cnt + 1 : W; end
          ROL:  begin nq = {m_q[6:0], m_q[7]};       nc = (m_cnt < W) ? m_cnt + 1 : W; end
          ROR:  begin nq = {m_q[0], m_q[7:1]};       nc = (m_cnt < W) ? m_cnt + 1 : W; end
          SET:  begin nq = 8'hFF;                    nc = 0; end
          CLR:  begin nq = 8'h00;                    nc = 0; end
          default: ;
        endcase
      end
      apply(1000 + k, r, e, m, dd, sl, sr, nq, nc);
    end

    chk("scoreboard_drained", 9999, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
